// File: rtl/program_run_ctrl_pkg.sv
// Shared definitions for the program run controller.
// Holds the FSM state encoding and the default sizing values so that the
// RTL and any bench instantiating the controller agree on them.
package program_run_ctrl_pkg;

  // Default sizing; benches reuse these rather than repeating literals.
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_RUNS_W      = 4;
  localparam int unsigned DEF_INIT_CYCLES = 1;
  localparam int unsigned DEF_TIMEOUT     = 5000;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT    = 2'd1,
    ST_RUN     = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

  // Every state other than IDLE counts as busy.
  function automatic logic is_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/program_run_ctrl_run_cycle_counter.sv
// Per-run cycle counter for the program run controller.
// Ports:
//   clock       system clock
//   init        asynchronous active-high reset
//   clear       synchronous clear to 0 (priority over enable)
//   enable      increment by one
//   count       current count
//   at_limit_c  combinational flag, count equals TIMEOUT
module run_cycle_counter
  import program_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             init,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             at_limit_c
);

  // Count register; the controller leaves RUN at TIMEOUT so it never wraps.
  always_ff @(posedge clock or posedge init) begin
    if (init) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal-count flag.
  assign at_limit_c = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/program_run_ctrl.sv
// Upstream sequencer for processor_3.
// Runs one program num_runs times back-to-back, drives processor init/restart,
// times each run in clock cycles and aborts a run that reaches TIMEOUT cycles.
// Ports:
//   clock         system clock, posedge
//   init          asynchronous active-high reset
//   start         one-cycle request to begin a sequence, ignored while busy
//   num_runs      runs requested, sampled with start (0 means 1)
//   proc_done     done from processor_3
//   proc_init     init to processor_3, high during INIT
//   proc_restart  restart to processor_3, high during RESTART
//   busy          high outside IDLE
//   run_valid     one-cycle pulse, run_idx/run_cycles describe a completed run
//   run_idx       0-based index of the completed run
//   run_cycles    cycles taken by that run (RUN entry to done, inclusive)
//   all_done      one-cycle pulse, sequence finished (normally or by timeout)
//   timeout       sticky abort flag, cleared by the next accepted start
module program_run_ctrl
  import program_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned RUNS_W      = DEF_RUNS_W,
  parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              init,
  input  logic              start,
  input  logic [RUNS_W-1:0] num_runs,
  input  logic              proc_done,
  output logic              proc_init,
  output logic              proc_restart,
  output logic              busy,
  output logic              run_valid,
  output logic [RUNS_W-1:0] run_idx,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              all_done,
  output logic              timeout
);

  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  // Elaboration-time parameter sanity.
  if (INIT_CYCLES < 1) begin : g_bad_init_cycles
    $error("program_run_ctrl: INIT_CYCLES must be at least 1");
  end
  if ((TIMEOUT >> CNT_W) != 0) begin : g_bad_timeout
    $error("program_run_ctrl: TIMEOUT must be below 2**CNT_W");
  end

  state_t             state;
  state_t             state_n;
  logic [RUNS_W-1:0]  runs_last;
  logic [RUNS_W-1:0]  runs_last_n;
  logic [RUNS_W-1:0]  run_cnt;
  logic [RUNS_W-1:0]  run_cnt_n;
  logic [INIT_W-1:0]  init_cnt;
  logic [INIT_W-1:0]  init_cnt_n;
  logic               run_valid_n;
  logic               all_done_n;
  logic               timeout_n;
  logic [RUNS_W-1:0]  run_idx_n;
  logic [CNT_W-1:0]   run_cycles_n;
  logic [CNT_W-1:0]   cyc;
  logic               at_limit_c;
  logic               done_ok_c;
  logic               cnt_clear_c;
  logic               cnt_en_c;

  // Cycle counter: cleared outside RUN and stepped on the edge entering RUN,
  // so it reads 1 in the first RUN cycle.
  run_cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_counter (
    .clock      (clock),
    .init       (init),
    .clear      (cnt_clear_c),
    .enable     (cnt_en_c),
    .count      (cyc),
    .at_limit_c (at_limit_c)
  );

  assign cnt_en_c    = (state_n == ST_RUN);
  assign cnt_clear_c = (state_n != ST_RUN);

  // A done seen in the first RUN cycle is left over from the previous run.
  assign done_ok_c = proc_done && (cyc >= CNT_W'(2));

  // State register.
  always_ff @(posedge clock or posedge init) begin
    if (init) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    runs_last_n  = runs_last;
    run_cnt_n    = run_cnt;
    init_cnt_n   = init_cnt;
    run_valid_n  = 1'b0;
    all_done_n   = 1'b0;
    timeout_n    = timeout;
    run_idx_n    = run_idx;
    run_cycles_n = run_cycles;

    case (state)
      ST_IDLE: begin
        if (start) begin
          // Store the index of the final run; a request of 0 runs means 1.
          runs_last_n = (num_runs == '0) ? '0 : (num_runs - RUNS_W'(1));
          run_cnt_n   = '0;
          init_cnt_n  = '0;
          timeout_n   = 1'b0;
          state_n     = ST_INIT;
        end
      end

      ST_INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
          state_n = ST_RUN;
        end else begin
          init_cnt_n = init_cnt + INIT_W'(1);
        end
      end

      ST_RUN: begin
        // Done is checked first so a done on the TIMEOUT cycle still completes.
        if (done_ok_c) begin
          run_valid_n  = 1'b1;
          run_cycles_n = cyc;
          run_idx_n    = run_cnt;
          if (run_cnt == runs_last) begin
            all_done_n = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            state_n = ST_RESTART;
          end
        end else if (at_limit_c) begin
          timeout_n  = 1'b1;
          all_done_n = 1'b1;
          state_n    = ST_IDLE;
        end
      end

      ST_RESTART: begin
        run_cnt_n = run_cnt + RUNS_W'(1);
        state_n   = ST_RUN;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output and bookkeeping registers; pin levels follow the state being entered.
  always_ff @(posedge clock or posedge init) begin
    if (init) begin
      runs_last    <= '0;
      run_cnt      <= '0;
      init_cnt     <= '0;
      proc_init    <= 1'b0;
      proc_restart <= 1'b0;
      busy         <= 1'b0;
      run_valid    <= 1'b0;
      run_idx      <= '0;
      run_cycles   <= '0;
      all_done     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      runs_last    <= runs_last_n;
      run_cnt      <= run_cnt_n;
      init_cnt     <= init_cnt_n;
      proc_init    <= (state_n == ST_INIT);
      proc_restart <= (state_n == ST_RESTART);
      busy         <= is_busy(state_n);
      run_valid    <= run_valid_n;
      run_idx      <= run_idx_n;
      run_cycles   <= run_cycles_n;
      all_done     <= all_done_n;
      timeout      <= timeout_n;
    end
  end

endmodule

// File: tb/tb_program_run_ctrl.sv
// Directed bench for program_run_ctrl with TIMEOUT reduced to 100 cycles.
module tb_program_run_ctrl;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RUNS_W  = 4;
  localparam int unsigned TIMEOUT = 100;

  logic              clock;
  logic              init;
  logic              start;
  logic [RUNS_W-1:0] num_runs;
  logic              proc_done;
  logic              proc_init;
  logic              proc_restart;
  logic              busy;
  logic              run_valid;
  logic [RUNS_W-1:0] run_idx;
  logic [CNT_W-1:0]  run_cycles;
  logic              all_done;
  logic              timeout;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  program_run_ctrl #(
    .CNT_W       (CNT_W),
    .RUNS_W      (RUNS_W),
    .INIT_CYCLES (1),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clock        (clock),
    .init         (init),
    .start        (start),
    .num_runs     (num_runs),
    .proc_done    (proc_done),
    .proc_init    (proc_init),
    .proc_restart (proc_restart),
    .busy         (busy),
    .run_valid    (run_valid),
    .run_idx      (run_idx),
    .run_cycles   (run_cycles),
    .all_done     (all_done),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last posedge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    init      = 1'b1;
    start     = 1'b0;
    num_runs  = '0;
    proc_done = 1'b0;

    // Reset state.
    tick(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_proc_init", 32'(proc_init), 32'd0);
    check("rst_run_valid", 32'(run_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    init = 1'b0;
    tick();

    // 1: single run, done at cycle 40.
    start = 1'b1; num_runs = 4'd1;
    tick();
    start = 1'b0;
    check("t1_init_hi", 32'(proc_init), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();                                  // first RUN cycle, cyc=1
    check("t1_init_lo", 32'(proc_init), 32'd0);
    tick(39);                                // cyc=40
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("t1_valid", 32'(run_valid), 32'd1);
    check("t1_idx", 32'(run_idx), 32'd0);
    check("t1_cycles", 32'(run_cycles), 32'd40);
    check("t1_all_done", 32'(all_done), 32'd1);
    tick();
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_valid_pulse", 32'(run_valid), 32'd0);
    check("t1_all_done_pulse", 32'(all_done), 32'd0);
    check("t1_cycles_hold", 32'(run_cycles), 32'd40);

    // 2: three runs of 10/20/30 cycles.
    start = 1'b1; num_runs = 4'd3;
    tick();
    start = 1'b0;
    tick();                                  // run 0, cyc=1
    tick(9);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("t2_r0_valid", 32'(run_valid), 32'd1);
    check("t2_r0_idx", 32'(run_idx), 32'd0);
    check("t2_r0_cycles", 32'(run_cycles), 32'd10);
    check("t2_r0_all_done", 32'(all_done), 32'd0);
    check("t2_r0_restart", 32'(proc_restart), 32'd1);
    tick();                                  // run 1, cyc=1
    check("t2_r0_restart_1cyc", 32'(proc_restart), 32'd0);
    check("t2_r0_valid_pulse", 32'(run_valid), 32'd0);
    tick(19);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("t2_r1_valid", 32'(run_valid), 32'd1);
    check("t2_r1_idx", 32'(run_idx), 32'd1);
    check("t2_r1_cycles", 32'(run_cycles), 32'd20);
    check("t2_r1_all_done", 32'(all_done), 32'd0);
    check("t2_r1_restart", 32'(proc_restart), 32'd1);
    tick();                                  // run 2, cyc=1
    check("t2_r1_restart_1cyc", 32'(proc_restart), 32'd0);
    tick(29);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("t2_r2_valid", 32'(run_valid), 32'd1);
    check("t2_r2_idx", 32'(run_idx), 32'd2);
    check("t2_r2_cycles", 32'(run_cycles), 32'd30);
    check("t2_r2_all_done", 32'(all_done), 32'd1);
    check("t2_r2_restart", 32'(proc_restart), 32'd0);
    tick();
    check("t2_busy_low", 32'(busy), 32'd0);

    // 3: stale done held from before start.
    proc_done = 1'b1;
    tick();
    start = 1'b1; num_runs = 4'd1;
    tick();
    start = 1'b0;
    tick();                                  // cyc=1, done ignored
    check("t3_c1_valid", 32'(run_valid), 32'd0);
    tick();                                  // cyc=2
    check("t3_c2_valid", 32'(run_valid), 32'd0);
    tick();
    proc_done = 1'b0;
    check("t3_valid", 32'(run_valid), 32'd1);
    check("t3_cycles", 32'(run_cycles), 32'd2);
    check("t3_all_done", 32'(all_done), 32'd1);
    tick();

    // 4: timeout with no done.
    start = 1'b1; num_runs = 4'd2;
    tick();
    start = 1'b0;
    tick();                                  // cyc=1
    tick(99);                                // cyc=100
    check("t4_c100_timeout", 32'(timeout), 32'd0);
    check("t4_c100_busy", 32'(busy), 32'd1);
    tick();
    check("t4_timeout", 32'(timeout), 32'd1);
    check("t4_all_done", 32'(all_done), 32'd1);
    check("t4_valid", 32'(run_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_restart", 32'(proc_restart), 32'd0);
    check("t4_cycles_hold", 32'(run_cycles), 32'd2);
    tick();
    check("t4_timeout_sticky", 32'(timeout), 32'd1);
    check("t4_all_done_pulse", 32'(all_done), 32'd0);

    // 6: next start clears timeout; start during RUN ignored; done on TIMEOUT cycle.
    start = 1'b1; num_runs = 4'd1;
    tick();
    start = 1'b0;
    check("t6_timeout_clr", 32'(timeout), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    tick();                                  // cyc=1
    tick(3);                                 // cyc=4
    start = 1'b1; num_runs = 4'd5;
    tick();                                  // cyc=5
    start = 1'b0;
    check("t6_busy_run", 32'(busy), 32'd1);
    tick(95);                                // cyc=100
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("t6_valid", 32'(run_valid), 32'd1);
    check("t6_cycles", 32'(run_cycles), 32'd100);
    check("t6_idx", 32'(run_idx), 32'd0);
    check("t6_timeout", 32'(timeout), 32'd0);
    check("t6_all_done", 32'(all_done), 32'd1);
    tick();
    check("t6_busy_low", 32'(busy), 32'd0);
    tick();
    check("t6_no_pending_start", 32'(busy), 32'd0);

    // 5: asynchronous reset during run 1 of 3.
    start = 1'b1; num_runs = 4'd3;
    tick();
    start = 1'b0;
    tick();                                  // run 0, cyc=1
    tick(4);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("t5_r0_cycles", 32'(run_cycles), 32'd5);
    tick();                                  // run 1, cyc=1
    tick(3);
    check("t5_pre_busy", 32'(busy), 32'd1);
    init = 1'b1;
    #2;                                      // no clock edge in between
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cycles", 32'(run_cycles), 32'd0);
    check("t5_idx", 32'(run_idx), 32'd0);
    check("t5_proc_init", 32'(proc_init), 32'd0);
    check("t5_proc_restart", 32'(proc_restart), 32'd0);
    check("t5_valid", 32'(run_valid), 32'd0);
    check("t5_all_done", 32'(all_done), 32'd0);
    check("t5_timeout", 32'(timeout), 32'd0);
    tick(2);
    init = 1'b0;
    tick();
    start = 1'b1; num_runs = 4'd0;
    tick();
    start = 1'b0;
    tick();                                  // cyc=1
    tick(2);                                 // cyc=3
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("t5_z_valid", 32'(run_valid), 32'd1);
    check("t5_z_idx", 32'(run_idx), 32'd0);
    check("t5_z_cycles", 32'(run_cycles), 32'd3);
    check("t5_z_all_done", 32'(all_done), 32'd1);
    check("t5_z_restart", 32'(proc_restart), 32'd0);
    tick();
    check("t5_z_busy_low", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
